pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, meaning MEM_WAIT cycles before mem_timeout sets (1..255).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the performance counters.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: id_rs, id_rt  in  2 each  source registers of the ID-stage instruction.
REQ-006 SHALL have ports: id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads that operand.
REQ-007 SHALL have ports: ex_rd  in  2  destination register of the EX-stage instruction.
REQ-008 SHALL have ports: ex_mem_read, ex_reg_write  in  1 each  EX instruction is a load / writes the register file.
REQ-009 SHALL have ports: ex_branch_taken  in  1  EX-resolved branch or jump is taken.
REQ-010 SHALL have ports: mem_req, mem_ready  in  1 each  MEM-stage data-memory request / completion handshake.
REQ-011 SHALL have ports: pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  pipeline-register load enables.
REQ-012 SHALL have ports: if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  insert bubble into that register.
REQ-013 SHALL have ports: mem_timeout  out  1  sticky wait-limit flag.
REQ-014 SHALL have ports: stall_cycles, flush_count  out  CNT_W each  saturating performance counters.

Function
REQ-015 SHALL define freeze = mem_req AND NOT mem_ready, evaluated every cycle regardless of state.
REQ-016 On freeze, SHALL drive all five write enables to 0 and mem_wb_flush to 1; if_id_flush and id_ex_flush SHALL be 0.
REQ-017 With no freeze and ex_branch_taken=1, SHALL drive all write enables to 1 and if_id_flush=1, id_ex_flush=1.
REQ-018 load_use = ex_mem_read AND ex_reg_write AND ((id_uses_rs AND ex_rd==id_rs) OR (id_uses_rt AND ex_rd==id_rt)).
REQ-019 With no freeze, no branch, and load_use=1, SHALL drive pc_write=0, if_id_write=0, id_ex_flush=1; other enables 1.
REQ-020 Otherwise SHALL drive all write enables 1 and all flushes 0.
REQ-021 Priority SHALL be freeze > branch > load_use; a branch held under freeze SHALL act in the first unfrozen cycle.
REQ-022 All enables and flushes SHALL be combinational from current inputs; zero-cycle latency.
REQ-023 FSM SHALL have states RUN and MEM_WAIT; RUN->MEM_WAIT when freeze; MEM_WAIT->RUN when mem_ready=1 or mem_req=0.
REQ-024 mem_req and mem_ready both 1 in RUN SHALL cause no wait: state stays RUN.
REQ-025 In the MEM_WAIT cycle that sees mem_ready=1, SHALL advance the pipeline normally, with REQ-017/019 applying.
REQ-026 wait_cnt (8 bits) SHALL clear on RUN->MEM_WAIT and increment each MEM_WAIT cycle, saturating at 255.
REQ-027 mem_timeout SHALL set when wait_cnt reaches WAIT_LIMIT and hold until rst; freeze SHALL continue.
REQ-028 stall_cycles SHALL increment on each freeze or load_use stall cycle, saturating at all-ones.
REQ-029 flush_count SHALL increment once per cycle with if_id_flush=1, saturating at all-ones.

Reset
REQ-030 rst SHALL set state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0 and flush_count=0 on the next clk edge.
REQ-031 While rst=1, combinational outputs SHALL still follow REQ-015..020; reset in mid-MEM_WAIT SHALL return to RUN.

Structure
REQ-032 State encoding (RUN=0, MEM_WAIT=1) and the 2-bit register-index width SHALL live in the shared pipeline package.
REQ-033 A sub-module sat_counter (width-parameterised, saturating, sync clear) SHALL implement both performance counters.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=2, id_rs=2, id_uses_rs=1 -> pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles +1.
REQ-035 Unused operand: as REQ-034 but id_uses_rs=0 and id_rt=1 -> no stall, all enables 1.
REQ-036 Branch plus load_use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1, flush_count +1.
REQ-037 mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles with mem_wb_flush=1, stall_cycles +3, RUN after ready.
REQ-038 WAIT_LIMIT=4, mem_ready held 0 -> mem_timeout=1 after the 4th MEM_WAIT cycle, stays 1 until rst.
REQ-039 rst during MEM_WAIT -> state RUN, counters 0, mem_timeout 0 on the next edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared FSM state encoding, register-index type and operand-hit helper
package pipeline_hazard_ctrl_pkg;
  localparam int REG_W = 2;
  localparam int WAIT_W = 8;
  typedef logic [REG_W-1:0] reg_idx_t;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_e;
  function automatic logic reg_hit(input logic uses, input reg_idx_t src, input reg_idx_t dst);
    return uses && (src == dst);
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: W-bit up counter with sync clear (rst), counts on inc, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage hazard unit; freeze/branch/load-use enables+flushes, wait FSM, timeout, perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_idx_t         id_rs,
  input  reg_idx_t         id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  reg_idx_t         ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);
  hz_state_e state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic freeze, load_use, branch, lu_stall;
  assign freeze = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & ex_reg_write &
                    (reg_hit(id_uses_rs, id_rs, ex_rd) | reg_hit(id_uses_rt, id_rt, ex_rd));
  // A held branch needs no memory: it simply acts once freeze drops.
  assign branch = ~freeze & ex_branch_taken;
  assign lu_stall = ~freeze & ~ex_branch_taken & load_use;
  assign pc_write = ~freeze & ~lu_stall;
  assign if_id_write = ~freeze & ~lu_stall;
  assign id_ex_write = ~freeze;
  assign ex_mem_write = ~freeze;
  assign mem_wb_write = ~freeze;
  assign if_id_flush = branch;
  assign id_ex_flush = branch | lu_stall;
  assign mem_wb_flush = freeze;
  // RUN enters MEM_WAIT on freeze, MEM_WAIT leaves on ready or dropped request: both reduce to "frozen now".
  always_comb begin
    state_nxt = freeze ? MEM_WAIT : RUN;
    wait_nxt = (state == RUN) ? '0 : (wait_cnt == '1) ? wait_cnt : wait_cnt + 8'd1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == MEM_WAIT && wait_nxt >= LIMIT) mem_timeout <= 1'b1;
    end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(freeze | lu_stall), .count(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .rst(rst), .inc(if_id_flush), .count(flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table vectors, directed corner sequences and random run against a behavioural model
module tb_pipeline_hazard_ctrl;
  localparam int LIMIT = 4;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  typedef struct packed {
    logic [1:0] rs, rt;
    logic urs, urt;
    logic [1:0] rd;
    logic mr, rw, br, req, rdy;
  } in_t;
  typedef struct packed {
    in_t i;
    logic [7:0] e;
  } vec_t;
  logic clk = 0, rst = 1;
  logic [1:0] id_rs = 0, id_rt = 0, ex_rd = 0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0, ex_reg_write = 0;
  logic ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;
  int n_cmp = 0, n_bad = 0;
  int m_stall = 0, m_flush = 0, m_wc = 0;
  bit m_wait = 0, m_to = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.WAIT_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  wire [7:0] ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                     if_id_flush, id_ex_flush, mem_wb_flush};
  task automatic chk(input string n, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit is_lu(input in_t v);
    return v.mr && v.rw && ((v.urs && v.rd == v.rs) || (v.urt && v.rd == v.rt));
  endfunction
  // Expected control word {pc, if_id, id_ex, ex_mem, mem_wb writes, if_id, id_ex, mem_wb flushes}
  function automatic logic [7:0] exp_ctrl(input in_t v);
    if (v.req && !v.rdy) return 8'b00000_001;
    if (v.br) return 8'b11111_110;
    if (is_lu(v)) return 8'b00111_010;
    return 8'b11111_000;
  endfunction
  task automatic step(input in_t v, input logic r);
    bit fz;
    @(negedge clk);
    rst = r;
    {id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd} = {v.rs, v.rt, v.urs, v.urt, v.rd};
    {ex_mem_read, ex_reg_write, ex_branch_taken, mem_req, mem_ready} = {v.mr, v.rw, v.br, v.req, v.rdy};
    #1 chk("ctrl", ctrl, exp_ctrl(v));
    @(posedge clk);
    fz = v.req && !v.rdy;
    if (r) begin
      m_wait = 0; m_wc = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (fz || (is_lu(v) && !v.br)) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
      if (!fz && v.br) m_flush = (m_flush < MAXC) ? m_flush + 1 : MAXC;
      if (m_wait) begin
        m_wc = (m_wc < 255) ? m_wc + 1 : 255;
        if (m_wc >= LIMIT) m_to = 1;
      end else m_wc = 0;
      m_wait = fz;
    end
    #1;
    chk("mem_timeout", mem_timeout, m_to);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
  endtask
  in_t idle, lu, br_lu, frz, rdy, brv, v;
  vec_t tbl[10];
  initial begin
    idle = '0;
    lu = '0; lu.rs = 2; lu.urs = 1; lu.rd = 2; lu.mr = 1; lu.rw = 1;
    br_lu = lu; br_lu.br = 1;
    frz = '0; frz.req = 1;
    rdy = '0; rdy.req = 1; rdy.rdy = 1;
    brv = '0; brv.br = 1;
    tbl[0] = '{idle, 8'b11111_000};
    tbl[1] = '{lu, 8'b00111_010};
    v = lu; v.urs = 0; v.urt = 1; v.rt = 1; tbl[2] = '{v, 8'b11111_000};
    v = '0; v.rt = 3; v.urt = 1; v.rd = 3; v.mr = 1; v.rw = 1; tbl[3] = '{v, 8'b00111_010};
    v = lu; v.rw = 0; tbl[4] = '{v, 8'b11111_000};
    tbl[5] = '{br_lu, 8'b11111_110};
    v = brv; v.req = 1; tbl[6] = '{v, 8'b00000_001};
    v = lu; v.req = 1; v.rdy = 1; tbl[7] = '{v, 8'b00111_010};
    v = brv; v.rdy = 1; tbl[8] = '{v, 8'b11111_110};
    v = lu; v.req = 1; tbl[9] = '{v, 8'b00000_001};
    step(idle, 1);
    chk("reset_stall", stall_cycles, 0);
    chk("reset_flush", flush_count, 0);
    chk("reset_timeout", mem_timeout, 0);
    step(lu, 0);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_stall_cnt", stall_cycles, 1);
    step(idle, 1);
    step(br_lu, 0);
    chk("br_lu_pc_write", pc_write, 1);
    chk("br_lu_flushes", {if_id_flush, id_ex_flush}, 3);
    chk("br_lu_flush_cnt", flush_count, 1);
    step(idle, 1);
    for (int k = 0; k < 3; k++) begin
      step(frz, 0);
      chk("freeze_memwb_flush", mem_wb_flush, 1);
    end
    step(rdy, 0);
    chk("ready_pc_write", pc_write, 1);
    chk("freeze3_stall_cnt", stall_cycles, 3);
    for (int k = 0; k < 4; k++) step(frz, 0);
    chk("rerun_no_timeout", mem_timeout, 0);
    step(idle, 1);
    for (int k = 0; k < 4; k++) step(frz, 0);
    chk("timeout_before_limit", mem_timeout, 0);
    step(frz, 0);
    chk("timeout_at_limit", mem_timeout, 1);
    for (int k = 0; k < 3; k++) step(idle, 0);
    chk("timeout_sticky", mem_timeout, 1);
    step(frz, 0);
    step(frz, 0);
    step(frz, 1);
    chk("rst_ctrl_frozen", ctrl, 8'b00000_001);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_stall", stall_cycles, 0);
    step(idle, 0);
    for (int k = 0; k < 20; k++) step(brv, 0);
    chk("flush_saturate", flush_count, MAXC);
    step(idle, 1);
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].i, 0);
      chk($sformatf("tbl%0d", k), ctrl, tbl[k].e);
    end
    for (int k = 0; k < 600; k++) begin
      v = in_t'($urandom);
      v.rdy = ($urandom_range(0, 3) == 0);
      step(v, $urandom_range(0, 59) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
